// File: rtl/ps2_key_display.sv
// PS/2 scan-code decoder tracking the held key, its ASCII and a BCD press counter,
// shown on six active-low 7-segment digits. Optional E0-prefix support: PS2_EXT_PREFIX_EN.
module ps2_key_display #(
    parameter bit BLANK_ON_RELEASE = 1'b1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       code_valid,
    input  logic [7:0] code,
    input  logic [7:0] ascii_in,
    output logic       key_down,
    output logic [7:0] key_code,
    output logic [7:0] key_ascii,
    output logic       key_ext,
    output logic [7:0] press_cnt,
    output logic [7:0] hex0,
    output logic [7:0] hex1,
    output logic [7:0] hex2,
    output logic [7:0] hex3,
    output logic [7:0] hex4,
    output logic [7:0] hex5
);

    localparam logic [7:0] BYTE_BRK   = 8'hF0;
    localparam logic [7:0] SEG_BLANK  = 8'hFF;
`ifdef PS2_EXT_PREFIX_EN
    localparam logic [7:0] BYTE_EXT   = 8'hE0;

    typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXTBRK} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_BRK} state_t;
`endif

    state_t     state;
    state_t     state_nxt;
    logic       make_ev;
    logic       brk_ev;
    logic       ev_ext;
    logic       same_key;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = v[7:4];
        units = v[3:0];
        if (units == 4'd9) begin
            units = 4'd0;
            tens  = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
            units = units + 4'd1;
        end
        return {tens, units};
    endfunction

    function automatic logic [7:0] glyph(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Byte classification; only consumed on cycles with code_valid=1.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_nxt = state;
        make_ev   = 1'b0;
        brk_ev    = 1'b0;
        ev_ext    = 1'b0;
        case (state)
            S_IDLE: begin
                if (code == BYTE_BRK) begin
                    state_nxt = S_BRK;
`ifdef PS2_EXT_PREFIX_EN
                end else if (code == BYTE_EXT) begin
                    state_nxt = S_EXT;
`endif
                end else begin
                    make_ev = 1'b1;
                end
            end
            S_BRK: begin
                brk_ev    = 1'b1;
                state_nxt = S_IDLE;
            end
`ifdef PS2_EXT_PREFIX_EN
            S_EXT: begin
                if (code == BYTE_BRK) begin
                    state_nxt = S_EXTBRK;
                end else if (code != BYTE_EXT) begin
                    make_ev   = 1'b1;
                    ev_ext    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_EXTBRK: begin
                brk_ev    = 1'b1;
                ev_ext    = 1'b1;
                state_nxt = S_IDLE;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    assign same_key = key_down && (code == key_code) && (ev_ext == key_ext);

`ifdef PS2_EXT_PREFIX_EN
    logic key_ext_q;
    assign key_ext = key_ext_q;
`else
    assign key_ext = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!resetn) begin
            state     <= S_IDLE;
            key_down  <= 1'b0;
            key_code  <= 8'h00;
            key_ascii <= 8'h00;
            press_cnt <= 8'h00;
`ifdef PS2_EXT_PREFIX_EN
            key_ext_q <= 1'b0;
`endif
        end else if (code_valid) begin
            state <= state_nxt;
            // Typematic repeats of the held key fall through both branches untouched.
            if (make_ev && !same_key) begin
                key_down  <= 1'b1;
                key_code  <= code;
                key_ascii <= ascii_in;
                press_cnt <= bcd_inc(press_cnt);
`ifdef PS2_EXT_PREFIX_EN
                key_ext_q <= ev_ext;
`endif
            end else if (brk_ev && same_key) begin
                key_down <= 1'b0;
            end
        end
    end

    logic       blank;
    logic       dp_lit;
    logic [7:0] hi_code;

`ifdef PS2_EXT_PREFIX_EN
    assign dp_lit = key_down && key_ext;
`else
    assign dp_lit = 1'b0;
`endif

    assign blank   = BLANK_ON_RELEASE && !key_down;
    assign hi_code = glyph(key_code[7:4]);

    always_comb begin
        hex0 = blank ? SEG_BLANK : glyph(key_code[3:0]);
        hex1 = blank ? SEG_BLANK : {hi_code[7] & ~dp_lit, hi_code[6:0]};
        hex2 = blank ? SEG_BLANK : glyph(key_ascii[3:0]);
        hex3 = blank ? SEG_BLANK : glyph(key_ascii[7:4]);
        hex4 = glyph(press_cnt[3:0]);
        hex5 = glyph(press_cnt[7:4]);
    end

endmodule

// File: tb/tb_ps2_key_display.sv
// Self-checking bench for ps2_key_display: directed scenarios plus random byte
// streams compared against a prefix-flag reference model.
module tb_ps2_key_display;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       code_valid = 1'b0;
    logic [7:0] code = 8'h00;
    logic [7:0] ascii_in = 8'h00;
    logic       key_down;
    logic [7:0] key_code;
    logic [7:0] key_ascii;
    logic       key_ext;
    logic [7:0] press_cnt;
    logic [7:0] hex0, hex1, hex2, hex3, hex4, hex5;

    int tests = 0;
    int fails = 0;

`ifdef PS2_EXT_PREFIX_EN
    localparam bit EXT_EN = 1'b1;
`else
    localparam bit EXT_EN = 1'b0;
`endif

    logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model: held key plus two pending-prefix flags, count kept as an integer.
    bit         m_down;
    logic [7:0] m_code;
    logic [7:0] m_ascii;
    bit         m_ext;
    int         m_cnt;
    bit         m_brk_pend;
    bit         m_ext_pend;

    ps2_key_display dut (
        .clk(clk), .resetn(resetn), .code_valid(code_valid), .code(code), .ascii_in(ascii_in),
        .key_down(key_down), .key_code(key_code), .key_ascii(key_ascii), .key_ext(key_ext),
        .press_cnt(press_cnt), .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .hex4(hex4), .hex5(hex5)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_down = 0; m_code = 8'h00; m_ascii = 8'h00; m_ext = 0; m_cnt = 0;
        m_brk_pend = 0; m_ext_pend = 0;
    endtask

    task automatic model_byte(input logic [7:0] c, input logic [7:0] a);
        if (m_brk_pend) begin
            if (m_down && c == m_code && m_ext_pend == m_ext) m_down = 0;
            m_brk_pend = 0;
            m_ext_pend = 0;
        end else if (c == 8'hF0) begin
            m_brk_pend = 1;
        end else if (c == 8'hE0 && EXT_EN) begin
            m_ext_pend = 1;
        end else begin
            if (!(m_down && c == m_code && m_ext_pend == m_ext)) begin
                m_down  = 1;
                m_code  = c;
                m_ascii = a;
                m_ext   = m_ext_pend;
                m_cnt   = (m_cnt + 1) % 100;
            end
            m_ext_pend = 0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] e_cnt;
        logic [7:0] e_hex1;
        e_cnt  = {4'(m_cnt / 10), 4'(m_cnt % 10)};
        e_hex1 = glyph_tab[m_code[7:4]];
        if (EXT_EN && m_down && m_ext) e_hex1 = e_hex1 & 8'h7F;
        check({tag, ".key_down"},  {7'd0, key_down}, {7'd0, m_down});
        check({tag, ".key_code"},  key_code, m_code);
        check({tag, ".key_ascii"}, key_ascii, m_ascii);
        check({tag, ".key_ext"},   {7'd0, key_ext}, {7'd0, m_ext});
        check({tag, ".press_cnt"}, press_cnt, e_cnt);
        check({tag, ".hex0"}, hex0, m_down ? glyph_tab[m_code[3:0]] : 8'hFF);
        check({tag, ".hex1"}, hex1, m_down ? e_hex1 : 8'hFF);
        check({tag, ".hex2"}, hex2, m_down ? glyph_tab[m_ascii[3:0]] : 8'hFF);
        check({tag, ".hex3"}, hex3, m_down ? glyph_tab[m_ascii[7:4]] : 8'hFF);
        check({tag, ".hex4"}, hex4, glyph_tab[m_cnt % 10]);
        check({tag, ".hex5"}, hex5, glyph_tab[m_cnt / 10]);
    endtask

    task automatic send_byte(input string tag, input logic [7:0] c, input logic [7:0] a);
        @(negedge clk);
        code_valid = 1'b1;
        code       = c;
        ascii_in   = a;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        code       = 8'($urandom);
        ascii_in   = 8'($urandom);
        model_byte(c, a);
        check_all(tag);
    endtask

    // Asserts reset mid-cycle, checks the immediate effect, strobes a byte while held.
    task automatic do_reset(input string tag);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".async"});
        code_valid = 1'b1;
        code       = 8'h1C;
        ascii_in   = 8'h61;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        check_all({tag, ".held"});
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset("rst0");

        // Single press with explicit display values.
        send_byte("press1c", 8'h1C, 8'h61);
        check("press1c.hex0_c", hex0, 8'hC6);
        check("press1c.hex1_c", hex1, 8'hF9);
        check("press1c.hex2_c", hex2, 8'hF9);
        check("press1c.hex3_c", hex3, 8'h82);
        check("press1c.hex4_c", hex4, 8'hF9);
        check("press1c.hex5_c", hex5, 8'hC0);

        // Typematic repeats then release.
        send_byte("rep1", 8'h1C, 8'h61);
        send_byte("rep2", 8'h1C, 8'h61);
        send_byte("rel_f0", 8'hF0, 8'h00);
        send_byte("rel_1c", 8'h1C, 8'h00);
        check("rep.cnt_c", press_cnt, 8'h01);
        check("rep.down_c", {7'd0, key_down}, 8'h00);
        check("rep.hex0_c", hex0, 8'hFF);
        check("rep.hex4_c", hex4, 8'hF9);

        // Rollover: releasing the older key leaves the newer one held.
        do_reset("rst1");
        send_byte("roll_1c", 8'h1C, 8'h61);
        send_byte("roll_32", 8'h32, 8'h62);
        send_byte("roll_f0a", 8'hF0, 8'h00);
        send_byte("roll_r1c", 8'h1C, 8'h00);
        check("roll.down_after_1c", {7'd0, key_down}, 8'h01);
        send_byte("roll_f0b", 8'hF0, 8'h00);
        send_byte("roll_r32", 8'h32, 8'h00);
        check("roll.down_after_32", {7'd0, key_down}, 8'h00);
        check("roll.cnt_c", press_cnt, 8'h02);

        // BCD counter across 09->10 and 99->00.
        do_reset("rst2");
        for (int i = 1; i <= 100; i++) begin
            logic [7:0] c;
            c = 8'h10 + 8'(i % 64);
            send_byte("bcd_press", c, 8'($urandom));
            if (i == 10) check("bcd.10", press_cnt, 8'h10);
            if (i == 99) check("bcd.99", press_cnt, 8'h99);
            send_byte("bcd_f0", 8'hF0, 8'h00);
            send_byte("bcd_rel", c, 8'h00);
        end
        check("bcd.wrap00", press_cnt, 8'h00);

        // E0-prefixed key.
        do_reset("rst3");
        send_byte("ext_e0", 8'hE0, 8'h00);
        send_byte("ext_75", 8'h75, 8'h38);
`ifdef PS2_EXT_PREFIX_EN
        check("ext.key_ext_c", {7'd0, key_ext}, 8'h01);
        check("ext.hex1_c", hex1, 8'h78);
`else
        check("ext.cnt_c", press_cnt, 8'h02);
`endif
        check("ext.code_c", key_code, 8'h75);
        send_byte("ext_e0b", 8'hE0, 8'h00);
        send_byte("ext_f0", 8'hF0, 8'h00);
        send_byte("ext_r75", 8'h75, 8'h00);

        // Prefix discarded by reset.
        do_reset("rst4");
        send_byte("pfx_e0", 8'hE0, 8'h00);
        do_reset("rst5");
        send_byte("pfx_1c", 8'h1C, 8'h61);
        check("pfx.ext_c", {7'd0, key_ext}, 8'h00);
        check("pfx.cnt_c", press_cnt, 8'h01);

        // Random byte stream, biased toward prefixes and a few recurring keys.
        do_reset("rst6");
        for (int i = 0; i < 400; i++) begin
            logic [7:0] c;
            case ($urandom_range(0, 9))
                0, 1:    c = 8'hF0;
                2:       c = 8'hE0;
                3, 4:    c = 8'h1C;
                5:       c = 8'h32;
                6:       c = 8'h75;
                default: c = 8'($urandom);
            endcase
            send_byte("rand", c, 8'($urandom));
            if (i == 200) do_reset("rst_mid");
        end

        // Idle cycles hold state.
        repeat (5) @(posedge clk);
        #1;
        check_all("idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
